// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the requester handshakes, the shared response bus
// and the ALU datapath connection of alu_arbiter.
//   req0_*/req1_*   : valid/ready request channels with operands and op select
//   resp0/1_valid   : one-cycle response pulses; resp_resultado/resp_cero shared
//   alu_a/b/op      : registered operands driven to the external ALU
//   alu_resultado   : combinational ALU result
//   busy            : arbiter is sequencing an operation
// Modports: slave = arbiter side, master = requesters plus ALU side.
interface alu_arbiter_if #(
  parameter int M = 4,
  parameter int S = 3
);
  logic         req0_valid;
  logic         req0_ready;
  logic [M-1:0] req0_a;
  logic [M-1:0] req0_b;
  logic [S-1:0] req0_op;
  logic         req1_valid;
  logic         req1_ready;
  logic [M-1:0] req1_a;
  logic [M-1:0] req1_b;
  logic [S-1:0] req1_op;
  logic         resp0_valid;
  logic         resp1_valid;
  logic [M-1:0] resp_resultado;
  logic         resp_cero;
  logic [M-1:0] alu_a;
  logic [M-1:0] alu_b;
  logic [S-1:0] alu_op;
  logic [M-1:0] alu_resultado;
  logic         busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_resultado,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_resultado, resp_cero,
    output alu_a, alu_b, alu_op,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_resultado,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_resultado, resp_cero,
    input  alu_a, alu_b, alu_op,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter/sequencer for a shared combinational ALU.
// Grants one request per IDLE cycle, registers its operands onto the ALU for
// one EXEC cycle, captures result and zero flag, then pulses the owner's
// response for one RESP cycle. One operation every 3 cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave (request, response and ALU signals)
// Build option: ALU_ARB_FIXED_PRIORITY_EN makes requester 0 win every tie
// (round-robin otherwise).
//
// state | meaning
// IDLE  | waiting for a request; ready is combinational from the valids
// EXEC  | operand registers drive the ALU; result captured at the end
// RESP  | response pulse to the owner; returns to IDLE
module alu_arbiter #(
  parameter int M = 4,
  parameter int S = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   last_grant;
  logic   tie_pick0;
  logic   grant0;
  logic   grant1;

  // last_grant == 1 means requester 1 was served last, so requester 0 wins a tie.
`ifdef ALU_ARB_FIXED_PRIORITY_EN
  assign tie_pick0 = 1'b1;
`else
  assign tie_pick0 = last_grant;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant0         = 1'b0;
    grant1         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        grant0 = bus.req0_valid & (~bus.req1_valid | tie_pick0);
        grant1 = bus.req1_valid & ~grant0;
        // Ready is masked during reset so all outputs read zero while rst_n is low.
        bus.req0_ready = grant0 & rst_n;
        bus.req1_ready = grant1 & rst_n;
        if (grant0 || grant1) begin
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a          <= '0;
      bus.alu_b          <= '0;
      bus.alu_op         <= '0;
      owner              <= 1'b0;
      last_grant         <= 1'b1;
      bus.resp_resultado <= '0;
      bus.resp_cero      <= 1'b0;
    end else begin
      if (state == IDLE && (grant0 || grant1)) begin
        bus.alu_a  <= grant0 ? bus.req0_a  : bus.req1_a;
        bus.alu_b  <= grant0 ? bus.req0_b  : bus.req1_b;
        bus.alu_op <= grant0 ? bus.req0_op : bus.req1_op;
        owner      <= grant1;
        last_grant <= grant1;
      end
      if (state == EXEC) begin
        bus.resp_resultado <= bus.alu_resultado;
        bus.resp_cero      <= ~|bus.alu_resultado;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.resp0_valid = (state == RESP) & ~owner;
  assign bus.resp1_valid = (state == RESP) & owner;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int M = 4;
  localparam int S = 3;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  alu_arbiter_if #(.M(M), .S(S)) bus ();

  alu_arbiter #(.M(M), .S(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU for the bench.
  always_comb begin
    bus.alu_resultado = '0;
    case (bus.alu_op)
      OP_AND:  bus.alu_resultado = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_resultado = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_resultado = bus.alu_a ^ bus.alu_b;
      OP_ADD:  bus.alu_resultado = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_resultado = bus.alu_a - bus.alu_b;
      default: bus.alu_resultado = '0;
    endcase
  end

  typedef struct {
    bit         r;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       zero;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.busy, bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid,
            bus.resp_resultado, bus.resp_cero, bus.alu_a, bus.alu_b, bus.alu_op};
  endfunction

  task automatic drive(input bit r, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op);
    if (r) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input bit r, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] res, input logic zero);
    drive(r, 1'b1, a, b, op);
    #1;
    chk("idle_ready", {bus.req0_ready, bus.req1_ready, bus.busy}, {~r, r, 1'b0});
    @(posedge clk);
    #1;
    drive(r, 1'b0, 4'h0, 4'h0, 3'd0);
    @(negedge clk);
    chk("exec_alu", {bus.busy, bus.req0_ready, bus.req1_ready, bus.alu_a, bus.alu_b, bus.alu_op},
        {3'b100, a, b, op});
    @(negedge clk);
    chk("resp", {bus.busy, bus.resp0_valid, bus.resp1_valid, bus.resp_resultado, bus.resp_cero},
        {1'b1, ~r, r, res, zero});
    @(negedge clk);
    chk("back_idle", {bus.busy, bus.resp0_valid, bus.resp1_valid}, 3'b000);
  endtask

  initial begin
    int waited;
    bit exp1;
    n_vec  = 0;
    n_miss = 0;
    vecs[0] = '{r: 1'b0, a: 4'h5, b: 4'h3, op: OP_XOR, res: 4'h6, zero: 1'b0};
    vecs[1] = '{r: 1'b1, a: 4'hA, b: 4'hA, op: OP_XOR, res: 4'h0, zero: 1'b1};
    vecs[2] = '{r: 1'b0, a: 4'hC, b: 4'hA, op: OP_AND, res: 4'h8, zero: 1'b0};
    vecs[3] = '{r: 1'b1, a: 4'h9, b: 4'h7, op: OP_ADD, res: 4'h0, zero: 1'b1};
    vecs[4] = '{r: 1'b0, a: 4'h3, b: 4'h5, op: OP_OR,  res: 4'h7, zero: 1'b0};
    vecs[5] = '{r: 1'b1, a: 4'hF, b: 4'h1, op: OP_SUB, res: 4'hE, zero: 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 3'd0);
    repeat (2) @(negedge clk);
    chk("reset_state", all_outs(), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].zero);
    end

    // Busy hold: req1 raised during EXEC of a req0 op waits, operands intact.
    drive(1'b0, 1'b1, 4'h2, 4'h3, OP_ADD);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'h9, 4'h6, OP_OR);
    #1 chk("hold_exec_ready1", bus.req1_ready, 1'b0);
    @(negedge clk);
    chk("hold_resp", {bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp_resultado},
        {3'b010, 4'h5});
    @(negedge clk);
    chk("hold_idle_ready", {bus.req0_ready, bus.req1_ready, bus.busy}, 3'b010);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 4'h0, 4'h0, 3'd0);
    @(negedge clk);
    chk("hold_exec_alu", {bus.alu_a, bus.alu_b, bus.alu_op}, {4'h9, 4'h6, OP_OR});
    @(negedge clk);
    chk("hold_resp1", {bus.resp0_valid, bus.resp1_valid, bus.resp_resultado, bus.resp_cero},
        {2'b01, 4'hF, 1'b0});
    @(negedge clk);

    // Idle stability.
    for (int i = 0; i < 10; i++) begin
      chk("idle_stable", all_outs(), {5'b00000, 4'hF, 1'b0, 4'h9, 4'h6, OP_OR});
      @(negedge clk);
    end

    // Reset during EXEC drops the operation.
    drive(1'b0, 1'b1, 4'h5, 4'h5, OP_ADD);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midop_reset", all_outs(), 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("midop_reset_hold", all_outs(), 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_reset_quiet", {bus.busy, bus.resp0_valid, bus.resp1_valid}, 3'b000);
    end
    drive(1'b0, 1'b1, 4'h1, 4'h1, OP_ADD);
    drive(1'b1, 1'b1, 4'h2, 4'h2, OP_ADD);
    #1 chk("first_tie_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
    @(posedge clk);
    #1 begin
      drive(1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
      drive(1'b1, 1'b0, 4'h0, 4'h0, 3'd0);
    end
    @(negedge clk);
    chk("first_tie_alu", {bus.alu_a, bus.alu_b}, {4'h1, 4'h1});
    @(negedge clk);
    chk("first_tie_resp", {bus.resp0_valid, bus.resp1_valid, bus.resp_resultado}, {2'b10, 4'h2});
    @(negedge clk);

    // Contention: both valid continuously from reset.
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 4'h1, 4'h2, OP_ADD);
    drive(1'b1, 1'b1, 4'h4, 4'h4, OP_AND);
    #1 chk("cont_reset_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(bus.resp0_valid || bus.resp1_valid) && waited < 8);
      if (!(bus.resp0_valid || bus.resp1_valid)) begin
        chk("cont_timeout", 32'd0, 32'd1);
      end else begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        exp1 = 1'b0;
`else
        exp1 = k[0];
`endif
        chk("cont_grant", {bus.resp0_valid, bus.resp1_valid, bus.resp_resultado},
            {~exp1, exp1, exp1 ? 4'h4 : 4'h3});
        if (k > 0) chk("cont_spacing", waited, 3);
      end
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 3'd0);
    repeat (2) @(negedge clk);
    chk("cont_end_idle", {bus.busy, bus.req0_ready, bus.req1_ready}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
